// File: rtl/datamem_param_im.sv
// Byte-lane data RAM for the RV32IM AES core: registered read, request error flagging and a post-reset clear.
// Define DMEM_AES_PRELOAD_EN to load the AES test block into words 4..7 after the clear (needs ADDR_W>=3).
module datamem_param_im #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  req,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [31:0]           addr,
  input  logic [DATA_W-1:0]     datain,
  output logic [DATA_W-1:0]     dataout,
  output logic                  rvalid,
  output logic                  err,
  output logic                  busy
);
  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
`ifdef DMEM_AES_PRELOAD_EN
    S_PRELOAD = 2'd1,
`endif
    S_IDLE    = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic                r_busy;
  logic                r_rvalid;
  logic                r_err;
  logic [DATA_W-1:0]   r_dataout;
  logic [DATA_W-1:0]   r_ram [DEPTH];
`ifdef DMEM_AES_PRELOAD_EN
  logic [1:0]          r_pre_cnt;
`endif

  logic [ADDR_W-1:0]   w_idx;
  logic                w_oor;
  logic                w_we_ok;
  logic                w_accept;
  logic                w_is_rd;
  logic                w_wr_ok;
  logic [LANES-1:0]    w_wr_en;
  logic [ADDR_W-1:0]   w_wr_idx;
  logic [DATA_W-1:0]   w_wr_data;

  // Legal enables: one lane, an aligned lane pair, or every lane.
  function automatic logic f_we_legal(input logic [LANES-1:0] we_v);
    logic [LANES-1:0] pair;
    logic             ok;
    pair = LANES'(3);
    ok   = (we_v == {LANES{1'b1}}) || $onehot(we_v);
    for (int k = 0; k < LANES / 2; k++)
      if (we_v == (pair << (2 * k))) ok = 1'b1;
    return ok;
  endfunction

`ifdef DMEM_AES_PRELOAD_EN
  function automatic logic [DATA_W-1:0] f_preload(input logic [1:0] k);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int j = 0; j < LANES && j < 4; j++)
      v[8*j +: 8] = 8'(4 * int'(k) + j + 1);
    return v;
  endfunction
`endif

  assign w_idx    = addr[ADDR_W+1:2];
  assign w_oor    = (addr >> (ADDR_W + 2)) != 32'd0;
  assign w_we_ok  = f_we_legal(we);
  assign w_accept = req && (r_state == S_IDLE);
  assign w_is_rd  = (we == '0);
  assign w_wr_ok  = w_accept && !w_is_rd && !w_oor && w_we_ok;

  // The single write port is shared by the clear/preload sequencer and the CPU.
  always_comb begin
    w_wr_en   = '0;
    w_wr_idx  = w_idx;
    w_wr_data = datain;
    case (r_state)
      S_CLEAR: begin
        w_wr_en   = '1;
        w_wr_idx  = r_clr_ptr;
        w_wr_data = '0;
      end
`ifdef DMEM_AES_PRELOAD_EN
      S_PRELOAD: begin
        w_wr_en   = '1;
        w_wr_idx  = ADDR_W'(32'd4 + 32'(r_pre_cnt));
        w_wr_data = f_preload(r_pre_cnt);
      end
`endif
      default: if (w_wr_ok) w_wr_en = we;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (w_wr_en[i]) r_ram[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
      r_busy    <= 1'b1;
      r_dataout <= '0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
`ifdef DMEM_AES_PRELOAD_EN
      r_pre_cnt <= '0;
`endif
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
`ifdef DMEM_AES_PRELOAD_EN
            r_state   <= S_PRELOAD;
            r_pre_cnt <= '0;
`else
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
`endif
          end
        end
`ifdef DMEM_AES_PRELOAD_EN
        S_PRELOAD: begin
          r_pre_cnt <= r_pre_cnt + 1'b1;
          if (r_pre_cnt == 2'd3) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
`endif
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_rd) begin
              r_rvalid  <= 1'b1;
              r_err     <= w_oor;
              r_dataout <= w_oor ? '0 : r_ram[w_idx];
            end else if (w_oor || !w_we_ok) begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= S_CLEAR;
          r_clr_ptr <= '0;
          r_busy    <= 1'b1;
        end
      endcase
    end
  end

  assign dataout = r_dataout;
  assign rvalid  = r_rvalid;
  assign err     = r_err;
  assign busy    = r_busy;
endmodule

// File: tb/tb_datamem_param_im.sv
// Directed bench for datamem_param_im with a cycle-level behavioural model and literal spot checks.
// Honours DMEM_AES_PRELOAD_EN for the expected busy length and preloaded words.
module tb_datamem_param_im;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
`ifdef DMEM_AES_PRELOAD_EN
  localparam int          BUSY_LEN = 36;
  localparam logic [31:0] W4 = 32'h04030201;
  localparam logic [31:0] W5 = 32'h08070605;
`else
  localparam int          BUSY_LEN = 32;
  localparam logic [31:0] W4 = 32'h0;
  localparam logic [31:0] W5 = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic        req = 1'b0;
  logic [3:0]  we = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] datain = 32'd0;
  logic [31:0] dataout;
  logic        rvalid;
  logic        err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  datamem_param_im #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .clrn    (clrn),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .datain  (datain),
    .dataout (dataout),
    .rvalid  (rvalid),
    .err     (err),
    .busy    (busy)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: memory as a word array, busy as a count of edges since reset release.
  logic [31:0] m_mem [32];
  int          m_cyc;
  logic [31:0] m_dout;
  logic        m_rv;
  logic        m_err;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
`ifdef DMEM_AES_PRELOAD_EN
    m_mem[4] = 32'h04030201;
    m_mem[5] = 32'h08070605;
    m_mem[6] = 32'h0c0b0a09;
    m_mem[7] = 32'h100f0e0d;
`endif
    m_cyc  = 0;
    m_dout = 32'd0;
    m_rv   = 1'b0;
    m_err  = 1'b0;
  endtask

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_reset();
    end else begin
      m_rv  = 1'b0;
      m_err = 1'b0;
      if (m_cyc >= BUSY_LEN && req) begin
        if (we == 4'd0) begin
          m_rv = 1'b1;
          if (addr >= (32'd4 << ADDR_W)) begin
            m_err  = 1'b1;
            m_dout = 32'd0;
          end else begin
            m_dout = m_mem[int'(addr / 4)];
          end
        end else if (addr >= (32'd4 << ADDR_W) ||
                     !(we inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})) begin
          m_err = 1'b1;
        end else begin
          for (int i = 0; i < 4; i++)
            if (we[i]) m_mem[int'(addr / 4)][8*i +: 8] = datain[8*i +: 8];
        end
      end
      if (m_cyc < 100000) m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_cyc < BUSY_LEN));
      chk("rvalid", 32'(rvalid), 32'(m_rv));
      chk("err", 32'(err), 32'(m_err));
      chk("dataout", dataout, m_dout);
    end
  end

  task automatic do_op(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    req    = 1'b1;
    we     = w;
    addr   = a;
    datain = d;
    @(posedge clk);
    #2;
    req = 1'b0;
    we  = 4'd0;
  endtask

  task automatic read_chk(input string nm, input logic [31:0] a, input logic [31:0] exp_d,
                          input logic exp_e);
    do_op(4'd0, a, 32'd0);
    @(negedge clk);
    chk({nm, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({nm, "_data"}, dataout, exp_d);
    chk({nm, "_err"}, 32'(err), 32'(exp_e));
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL ready_timeout: busy still 1 after 200 cycles, required 0");
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    chk({nm, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({nm, "_err"}, 32'(err), 32'd0);
    chk({nm, "_dataout"}, dataout, 32'd0);
  endtask

  initial begin
    int n;
    #1 clrn = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk);
    #2 clrn = 1'b1;
    wait_ready(n);
    chk("busy_len", 32'(n), 32'(BUSY_LEN));
    read_chk("rd_w4", 32'h10, W4, 1'b0);

    do_op(4'b1111, 32'h20, 32'hdeadbeef);
    read_chk("rd_word", 32'h20, 32'hdeadbeef, 1'b0);
    do_op(4'b0100, 32'h20, 32'h00aa0000);
    read_chk("rd_byte", 32'h20, 32'hdeaabeef, 1'b0);
    do_op(4'b0011, 32'h22, 32'h00001234);
    read_chk("rd_half", 32'h20, 32'hdeaa1234, 1'b0);

    do_op(4'b0101, 32'h20, 32'hffffffff);
    @(negedge clk);
    chk("bad_we_err", 32'(err), 32'd1);
    chk("bad_we_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk);
    chk("bad_we_err_pulse", 32'(err), 32'd0);
    read_chk("rd_after_bad", 32'h20, 32'hdeaa1234, 1'b0);

    read_chk("rd_oor", 32'h80, 32'd0, 1'b1);
    do_op(4'b1111, 32'h80, 32'h55555555);
    @(negedge clk);
    chk("wr_oor_err", 32'(err), 32'd1);
    read_chk("rd_w0", 32'h00, 32'd0, 1'b0);

    do_op(4'd0, 32'h20, 32'd0);
    do_op(4'd0, 32'h10, 32'd0);
    do_op(4'd0, 32'h14, 32'd0);
    @(negedge clk);
    chk("b2b_last", dataout, W5);
    do_op(4'b1000, 32'h7f, 32'ha5000000);
    read_chk("rd_top_byte", 32'h7c, 32'ha5000000, 1'b0);

    do_op(4'b1111, 32'h50, 32'h11111111);
    read_chk("rd_w20", 32'h50, 32'h11111111, 1'b0);
    @(posedge clk);
    #2 clrn = 1'b0;
    @(posedge clk);
    #2 clrn = 1'b1;
    repeat (10) @(posedge clk);
    #2 clrn = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    @(posedge clk);
    #2 clrn = 1'b1;
    wait_ready(n);
    chk("busy_len2", 32'(n), 32'(BUSY_LEN));
    read_chk("rd_w20_clr", 32'h50, 32'd0, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
